// File: rtl/sd4_mac_seq_ctrl.sv
// sd4_mac_seq_ctrl
// Job sequencer for the SD4 MAC pipeline. It accepts one dot-product job of
// `len` vectors, admits them into the stage registers through a valid/ready
// handshake, and tracks one valid token per stage. From those tokens it
// derives the stage load enables and the accumulator clear/add controls. Once
// the pipe has drained it presents the result handshake. The block carries no
// datapath of its own.
module sd4_mac_seq_ctrl #(
  parameter int NSTAGE = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NSTAGE-1:0] stage_en,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [LEN_W-1:0]  vec_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NSTAGE-1:0]  vld_q, vld_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               acc_clear_q, acc_clear_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;

  logic               run_s;
  logic               accept_s;
  logic [LEN_W-1:0]   cnt_inc_s;
  logic               pipe_empty_s;

  // A vector is only taken while running. A flush in the same cycle cancels
  // the acceptance, so the vector is neither counted nor tokenised.
  assign run_s        = (state_q == ST_RUN);
  assign accept_s     = in_valid & run_s & ~flush;
  assign cnt_inc_s    = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
  // Everything except the last stage is empty: the last token, if any, is
  // accumulated on the coming edge.
  assign pipe_empty_s = (vld_q[NSTAGE-2:0] == {(NSTAGE-1){1'b0}});

  assign in_ready  = run_s;
  assign stage_en  = {vld_q[NSTAGE-2:0], accept_s};
  assign acc_en    = vld_q[NSTAGE-1];
  assign acc_clear = acc_clear_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign vec_cnt   = cnt_q;

  // Next-state logic: job sequencing, token shift, counters and output decode.
  always_comb begin
    state_d     = state_q;
    vld_d       = {vld_q[NSTAGE-2:0], accept_s};
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_clear_d = 1'b0;
    if (flush) begin
      // Abort: drop all in-flight tokens; the vector count is kept for debug.
      state_d = ST_IDLE;
      vld_d   = {NSTAGE{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (len != {LEN_W{1'b0}})) begin
            state_d     = ST_RUN;
            len_d       = len;
            cnt_d       = {LEN_W{1'b0}};
            acc_clear_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == len_q) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          vld_d   = {NSTAGE{1'b0}};
        end
      endcase
    end
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Sequencer state, token pipe and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      vld_q       <= {NSTAGE{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      acc_clear_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_clear_q <= acc_clear_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sd4_mac_seq_ctrl.sv
// tb_sd4_mac_seq_ctrl
// Stimulus tasks derive each job's timeline from the vector count, the
// in_valid pattern and the pipeline depth: acceptance cycles, token
// positions, the result cycle and the handshake cycle. They queue the
// expected per-cycle status, the acc_en events and the result transfers.
// An independent monitor samples on the falling edge and pops and compares
// those expectations.
module tb_sd4_mac_seq_ctrl;
  localparam int NSTAGE = 4;
  localparam int LEN_W  = 8;

  typedef struct {
    int                c;
    bit                busy;
    bit                rdy;
    int                cnt;
    bit                rv;
    bit                aclr;
    logic [NSTAGE-1:0] sen;
  } st_t;

  typedef struct {
    int c;
    int cnt;
  } rs_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len_in;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [NSTAGE-1:0] stage_en;
  logic              acc_clear;
  logic              acc_en;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic [LEN_W-1:0]  vec_cnt;

  sd4_mac_seq_ctrl #(.NSTAGE(NSTAGE), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len_in), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .stage_en(stage_en),
    .acc_clear(acc_clear), .acc_en(acc_en), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  last_cnt = 0;
  st_t stq[$];
  int  acc_q[$];
  rs_t res_q[$];
  bit  acc_set[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_st(input bit b, input bit r, input int cnt, input bit rv, input bit aclr);
    st_t s;
    s.c = cyc; s.busy = b; s.rdy = r; s.cnt = cnt; s.rv = rv; s.aclr = aclr;
    for (int i = 0; i < NSTAGE; i++) s.sen[i] = acc_set.exists(cyc - i) ? 1'b1 : 1'b0;
    stq.push_back(s);
  endfunction

  // Drop expectations of tokens killed at the end of cycle f.
  function automatic void purge(input int f);
    int tmp[$];
    for (int k = f - NSTAGE + 1; k <= f; k++) if (acc_set.exists(k)) acc_set.delete(k);
    foreach (acc_q[k]) if (acc_q[k] <= f) tmp.push_back(acc_q[k]);
    acc_q = tmp;
  endfunction

  // Monitor: per-cycle status plus acc_en and result events.
  st_t mon_e;
  rs_t mon_r;
  always @(negedge clk) begin
    if (stq.size() > 0) begin
      mon_e = stq.pop_front();
      chk("busy", int'(busy), int'(mon_e.busy));
      chk("in_ready", int'(in_ready), int'(mon_e.rdy));
      chk("vec_cnt", int'(vec_cnt), mon_e.cnt);
      chk("res_valid", int'(res_valid), int'(mon_e.rv));
      chk("acc_clear", int'(acc_clear), int'(mon_e.aclr));
      chk("stage_en", int'(stage_en), int'(mon_e.sen));
    end
    if (acc_q.size() > 0 && acc_q[0] < cyc) chk("acc_en_missed", cyc, acc_q.pop_front());
    if (acc_en) begin
      if (acc_q.size() > 0) chk("acc_en_cycle", cyc, acc_q.pop_front());
      else chk("acc_en_unexpected", int'(acc_en), 0);
    end
    if (res_q.size() > 0 && res_q[0].c < cyc) begin
      mon_r = res_q.pop_front();
      chk("res_missed", cyc, mon_r.c);
    end
    if (res_valid && res_ready) begin
      if (res_q.size() > 0) begin
        mon_r = res_q.pop_front();
        chk("res_cycle", cyc, mon_r.c);
        chk("res_cnt", int'(vec_cnt), mon_r.cnt);
      end else begin
        chk("res_unexpected", int'(res_valid), 0);
      end
    end
  end

  task automatic idle(input int n, input bit zero_start);
    repeat (n) begin
      start = zero_start ? 1'b1 : 1'($urandom_range(1));
      len_in = 8'd0;
      in_valid = 1'($urandom_range(1));
      res_ready = 1'($urandom_range(1));
      flush = ($urandom_range(3) == 0) ? 1'b1 : 1'b0;
      push_st(1'b0, 1'b0, last_cnt, 1'b0, 1'b0);
      step();
    end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic run_job(input int jlen, input int pv, input int d, input int flush_at,
                         input bit noisy, input logic [31:0] pat, input bit use_pat);
    int acc_n, k, lastacc, r_cyc, t_cyc;
    bit iv, first;
    rs_t r;
    start = 1'b1; len_in = 8'(jlen); flush = 1'b0;
    in_valid = 1'($urandom_range(1)); res_ready = 1'($urandom_range(1));
    push_st(1'b0, 1'b0, last_cnt, 1'b0, 1'b0);
    step();
    acc_n = 0; k = 0; first = 1'b1; lastacc = cyc;
    while (acc_n < jlen) begin
      if (use_pat) iv = (k < 32) ? pat[k] : 1'b1;
      else iv = (int'($urandom_range(99)) < pv);
      in_valid = iv;
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      len_in = noisy ? 8'($urandom) : 8'(jlen);
      res_ready = 1'($urandom_range(1));
      flush = 1'b0;
      if (flush_at != 0 && iv && acc_n == flush_at - 1) begin
        flush = 1'b1;
        push_st(1'b1, 1'b1, acc_n, 1'b0, first);
        last_cnt = acc_n;
        purge(cyc);
        step();
        flush = 1'b0; start = 1'b0; in_valid = 1'b0;
        return;
      end
      if (iv) begin
        acc_set[cyc] = 1'b1;
        acc_q.push_back(cyc + NSTAGE);
        lastacc = cyc;
      end
      push_st(1'b1, 1'b1, acc_n, 1'b0, first);
      if (iv) acc_n++;
      first = 1'b0; k++;
      step();
    end
    r_cyc = lastacc + NSTAGE + 1;
    t_cyc = r_cyc + d;
    for (int c = cyc; c <= t_cyc; c++) begin
      in_valid = 1'($urandom_range(1));
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      len_in = noisy ? 8'($urandom) : 8'(jlen);
      flush = 1'b0;
      if (c >= t_cyc) res_ready = 1'b1;
      else if (c < r_cyc) res_ready = 1'($urandom_range(1));
      else res_ready = 1'b0;
      push_st(1'b1, 1'b0, jlen, (c >= r_cyc), 1'b0);
      if (c == t_cyc) begin
        r.c = c; r.cnt = jlen;
        res_q.push_back(r);
      end
      step();
    end
    start = 1'b0; res_ready = 1'b0; in_valid = 1'b0;
    last_cnt = jlen;
  endtask

  // Job of 3 vectors, asynchronous reset asserted mid-cycle during drain.
  task automatic reset_in_drain();
    start = 1'b1; len_in = 8'd3; in_valid = 1'b0; res_ready = 1'b0; flush = 1'b0;
    push_st(1'b0, 1'b0, last_cnt, 1'b0, 1'b0);
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      acc_set[cyc] = 1'b1;
      acc_q.push_back(cyc + NSTAGE);
      push_st(1'b1, 1'b1, k, 1'b0, (k == 0));
      step();
    end
    in_valid = 1'b0;
    push_st(1'b1, 1'b0, 3, 1'b0, 1'b0);
    step();
    acc_set.delete();
    purge(cyc - 1);
    last_cnt = 0;
    push_st(1'b0, 1'b0, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    step();
    rst = 1'b1;
    push_st(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    int jl;
    rst = 1'b0; start = 1'b0; len_in = 8'd0; flush = 1'b0;
    in_valid = 1'b0; res_ready = 1'b0;
    step();
    push_st(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    push_st(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step();
    idle(2, 1'b1);
    run_job(3, 100, 0, 0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    idle(2, 1'b0);
    run_job(2, 0, 1, 0, 1'b0, 32'h0000_0009, 1'b1);
    idle(2, 1'b0);
    run_job(3, 70, 10, 0, 1'b1, 32'h0, 1'b0);
    idle(1, 1'b1);
    run_job(3, 100, 2, 0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    idle(1, 1'b0);
    run_job(5, 100, 0, 3, 1'b0, 32'hFFFF_FFFF, 1'b1);
    idle(3, 1'b0);
    reset_in_drain();
    run_job(1, 100, 0, 0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    idle(2, 1'b0);
    run_job(20, 60, 3, 0, 1'b1, 32'h0, 1'b0);
    repeat (30) begin
      jl = int'($urandom_range(6, 1));
      run_job(jl, int'($urandom_range(100, 30)), int'($urandom_range(5)),
              ($urandom_range(4) == 0) ? int'($urandom_range(jl, 1)) : 0,
              1'b1, 32'h0, 1'b0);
      idle(int'($urandom_range(3)), 1'b0);
    end
    idle(NSTAGE + 2, 1'b0);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd4_mac_seq_ctrl.md
Name: sd4_mac_seq_ctrl

Overview:
Job sequencer for the SD4 MAC pipeline: product generation, exponent-max/alignment, adder tree, normalisation and the accumulator.
- Accepts one dot-product job of `len` input vectors, where each vector is 9 signed partial products with exponents.
- Gates vectors into the pipeline through a valid/ready handshake and tracks a per-stage valid token.
- Drives the stage register enables, the accumulator clear/enable and the result handshake.
- Sits between the host/DMA feeder and the MAC stage registers. It has no datapath of its own.

Parameters:
- NSTAGE, 4: number of registered pipeline stages ahead of the accumulator. Must be at least 2.
- LEN_W, 8: width of the job length and vector counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- len  in  LEN_W  number of vectors in the job; latched on an accepted start
- flush  in  1  synchronous abort, highest priority after reset
- in_valid  in  1  feeder has a vector on the datapath inputs
- in_ready  out  1  controller accepts a vector this cycle
- stage_en  out  NSTAGE  per-stage register load enable
- acc_clear  out  1  accumulator synchronous clear
- acc_en  out  1  accumulator add enable
- res_valid  out  1  accumulator holds the final job result
- res_ready  in  1  consumer takes the result
- busy  out  1  state is not IDLE
- vec_cnt  out  LEN_W  vectors accepted in the current job

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Valid tokens vld[NSTAGE-1:0], vec_cnt, the latched length and acc_clear are all cleared to 0.
  - Every output is therefore 0.
- Reset is legal in any state, including mid-RUN or DRAIN. In-flight tokens are discarded and no result is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with len!=0: latch len, clear vec_cnt, go to RUN. acc_clear is a registered pulse, high for exactly the first RUN cycle.
  - start=1 with len=0: ignored, stay in IDLE.
  - start outside IDLE: ignored.
- in_ready is combinational and equals (state==RUN). A vector is accepted when acc = in_valid & in_ready.
- RUN, on an accepted vector:
  - vec_cnt increments.
  - If vec_cnt+1 == latched len, go to DRAIN.
  - in_valid=0 cycles are bubbles: no token is inserted and the count is unchanged.
- Token pipeline, every cycle:
  - vld[0] <= acc.
  - vld[i] <= vld[i-1].
  - stage_en[0] = acc.
  - stage_en[i] = vld[i-1] for i≥1 (combinational).
  - acc_en = vld[NSTAGE-1] (combinational).
- DRAIN:
  - in_ready=0.
  - When vld[NSTAGE-2:0]==0 (only the last stage is possibly still valid), go to DONE at the next edge. The final accumulate happens on that same edge.
- DONE:
  - res_valid=1 (registered, state-decoded).
  - Hold until res_ready=1, then go to IDLE. The result is transferred on the cycle where res_valid and res_ready are both 1.
  - start is ignored while res_valid is pending.
- Latency: the last accepted vector at cycle t gives acc_en at cycle t+NSTAGE and res_valid at cycle t+NSTAGE+1.
- vec_cnt holds its value through DRAIN and DONE and clears only on the next accepted start.
- flush=1 in any state:
  - Next cycle: state IDLE, vld cleared, res_valid=0, acc_clear=0.
  - It does not itself clear vec_cnt.
  - flush overrides a simultaneous start, acceptance or res_ready.
- Accumulator ordering: acc_clear and acc_en are never high in the same cycle. A new job's first acc_en occurs no earlier than NSTAGE cycles after its acc_clear.

Test Plan:
- Basic job, NSTAGE=4, len=3, start at cycle 0, in_valid held high:
  - RUN at cycle 1; acc_clear high in cycle 1 only.
  - Accepts at cycles 1, 2, 3; DRAIN from cycle 4.
  - acc_en in cycles 5–7; res_valid at cycle 8.
  - With res_ready=1 at cycle 8: IDLE at cycle 9 and vec_cnt=3.
- Bubbles, len=2, in_valid high only in cycles 1 and 4:
  - stage_en[0] high in cycles 1 and 4; acc_en high in cycles 5 and 8.
  - res_valid at cycle 9; vec_cnt 1 then 2.
- Backpressure:
  - res_ready held low 10 cycles after res_valid → res_valid stays 1, state stays DONE, start pulses ignored.
  - res_ready=1 → IDLE next cycle.
- Illegal and late starts:
  - start with len=0 → busy stays 0.
  - start during RUN with a different len → original len is honoured and vec_cnt ends at the original len.
- Flush mid-job, len=5, flush at the third acceptance cycle:
  - Next cycle: IDLE, vld=0, no acc_en afterwards, res_valid never set.
  - A simultaneous in_valid is not counted.
- Reset in DRAIN: assert rst low asynchronously between edges → all outputs 0 immediately. After release with start and len=1 → full job, res_valid 5 cycles after the acceptance.
